// File: rtl/karatsuba_seq_mul_if.sv
// karatsuba_seq_mul_if
//   Bundles the producer-side and consumer-side handshakes of karatsuba_seq_mul.
//   Signals:
//     in_valid  producer -> block   operands valid
//     in_ready  block -> producer   block can accept operands
//     input_0   producer -> block   operand A (N bits)
//     input_1   producer -> block   operand B (N bits)
//     out_valid block -> consumer   output_2 holds a completed product
//     out_ready consumer -> block   consumer accepts output_2
//     output_2  block -> consumer   product A*B (2N bits)
//     busy      block -> observer   block is not idle
//   master: the environment (producer + consumer); slave: the multiplier.
interface karatsuba_seq_mul_if #(
  parameter int N = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     input_0;
  logic [N-1:0]     input_1;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   output_2;
  logic             busy;

  modport master (
    output in_valid, input_0, input_1, out_ready,
    input  in_ready, out_valid, output_2, busy
  );

  modport slave (
    input  in_valid, input_0, input_1, out_ready,
    output in_ready, out_valid, output_2, busy
  );
endinterface

// File: rtl/karatsuba_seq_mul.sv
// karatsuba_seq_mul
//   Sequential single-level Karatsuba multiplier. Each operand is split once into
//   low/high halves; the three partial products z0 = lo*lo, z2 = hi*hi and
//   zm = (lo+hi)*(lo+hi) are formed one after another on one shared shift-add
//   datapath (one multiplier bit per cycle), then combined into the product.
//   Optional two's-complement mode works on magnitudes and fixes the sign at the end.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          slave side of karatsuba_seq_mul_if (handshakes, operands, product, busy)
//   dbg_state_o  current FSM state encoding (IDLE=0 .. DONE=5)
// Handshake semantics: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE (and low while rst_n is low); out_valid is
//   high only in DONE and output_2 is held stable until out_ready completes the transfer.
//   Accept and deliver can never occur in the same cycle.
module karatsuba_seq_mul #(
  parameter int N      = 10,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  karatsuba_seq_mul_if.slave   bus,
  output logic [2:0]           dbg_state_o
);

  localparam int H  = (N + 1) >> 1;   // low-half width
  localparam int W  = H + 1;          // sub-product operand width
  localparam int CW = $clog2(W);      // bit counter width, holds 0..W-1

  localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_LO  = 3'd1,
    S_MUL_HI  = 3'd2,
    S_MUL_MID = 3'd3,
    S_COMBINE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_lo_q, a_lo_d, a_hi_q, a_hi_d;
  logic [W-1:0]     b_lo_q, b_lo_d, b_hi_q, b_hi_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   z0_q, z0_d, z2_q, z2_d;
  logic [2*N-1:0]   out_q, out_d;

  // Operand magnitudes; |-2^(N-1)| = 2^(N-1) still fits in N unsigned bits.
  logic [N-1:0] mag_a, mag_b;
  logic         sign_a, sign_b;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = bus.input_0;
    mag_b  = bus.input_1;
    if (SIGNED) begin
      sign_a = bus.input_0[N-1];
      sign_b = bus.input_1[N-1];
      if (sign_a) mag_a = ~bus.input_0 + ONE_N;
      if (sign_b) mag_b = ~bus.input_1 + ONE_N;
    end
  end

  // Half sums cannot overflow W bits: both halves are at most 2^H - 1.
  logic [W-1:0] as_w, bs_w;
  assign as_w = a_lo_q + a_hi_q;
  assign bs_w = b_lo_q + b_hi_q;

  // Shared shift-add step: operand pair chosen by the current multiply state.
  logic [W-1:0]   mcand, mplier;
  logic [2*W-1:0] pp, acc_nxt;

  always_comb begin
    mcand  = '0;
    mplier = '0;
    case (state_q)
      S_MUL_LO:  begin mcand = a_lo_q; mplier = b_lo_q; end
      S_MUL_HI:  begin mcand = a_hi_q; mplier = b_hi_q; end
      S_MUL_MID: begin mcand = as_w;   mplier = bs_w;   end
      default:   ;
    endcase
    pp      = mplier[cnt_q] ? ((2*W)'(mcand) << cnt_q) : '0;
    acc_nxt = acc_q + pp;
  end

  // Combination. zm sits in acc_q when COMBINE starts. Only the low 2N bits of the
  // wide sum are kept (the upper bits are always zero), so modular 2N-bit arithmetic
  // gives the same result as the wide sum followed by truncation.
  logic [2*W-1:0] z1;
  logic [2*N-1:0] p_mag, p_fin;

  always_comb begin
    z1    = acc_q - z0_q - z2_q;
    p_mag = ((2*N)'(z2_q) << (2*H)) + ((2*N)'(z1) << H) + (2*N)'(z0_q);
    p_fin = sign_q ? (~p_mag + ONE_2N) : p_mag;
  end

  always_comb begin
    state_d = state_q;
    a_lo_d  = a_lo_q;
    a_hi_d  = a_hi_q;
    b_lo_d  = b_lo_q;
    b_hi_d  = b_hi_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_lo_d  = W'(mag_a[H-1:0]);
          a_hi_d  = W'(mag_a[N-1:H]);
          b_lo_d  = W'(mag_b[H-1:0]);
          b_hi_d  = W'(mag_b[N-1:H]);
          sign_d  = sign_a ^ sign_b;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_MUL_LO;
        end
      end
      S_MUL_LO, S_MUL_HI, S_MUL_MID: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = '0;
          case (state_q)
            S_MUL_LO: begin
              z0_d    = acc_nxt;
              acc_d   = '0;
              state_d = S_MUL_HI;
            end
            S_MUL_HI: begin
              z2_d    = acc_nxt;
              acc_d   = '0;
              state_d = S_MUL_MID;
            end
            default: state_d = S_COMBINE;   // zm stays in the accumulator
          endcase
        end
      end
      S_COMBINE: begin
        out_d   = p_fin;
        acc_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_lo_q  <= '0;
      a_hi_q  <= '0;
      b_lo_q  <= '0;
      b_hi_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_lo_q  <= a_lo_d;
      a_hi_q  <= a_hi_d;
      b_lo_q  <= b_lo_d;
      b_hi_q  <= b_hi_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.output_2  = out_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule
